// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that lets NUM_REQ requesters share one UART transmitter.
// A grant latches the winner's byte and index, then one start pulse launches it.
module uart_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [NUM_REQ-1:0]            iReq,
  input  logic [NUM_REQ*DATA_W-1:0]     iData,
  output logic [NUM_REQ-1:0]            oGnt,
  output logic                          oStart,
  output logic [DATA_W-1:0]             oData_tx,
  input  logic                          iBusy_tx,
  output logic [$clog2(NUM_REQ)-1:0]    oOwner,
  output logic                          oIdle,
  output logic                          oTimeout,
  output logic [1:0]                    oState
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [IDX_W-1:0]   last, sel;
  logic               found;
  logic               grant_fire;

  // Search starts just after the last granted index and wraps.
  always_comb begin
    int cand;
    found = 1'b0;
    sel   = last;
    cand  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last) + i) % NUM_REQ;
      if (!found && iReq[cand]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_fire = 1'b0;
    oStart     = 1'b0;
    oTimeout   = 1'b0;
    case (state)
      IDLE: begin
        if (found && !iBusy_tx) begin
          grant_fire = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        oStart     = 1'b1;
        cnt_next   = '0;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (iBusy_tx) begin
          state_next = WAIT_DONE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT)) begin
          oTimeout   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!iBusy_tx) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant is combinational in IDLE; masked so reset forces it low immediately.
  always_comb begin
    oGnt = '0;
    if (grant_fire && !iRst) oGnt[sel] = 1'b1;
  end

  assign oIdle  = (state == IDLE);
  assign oState = state;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= IDX_W'(NUM_REQ - 1);
      oData_tx <= '0;
      oOwner   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (grant_fire) begin
        last     <= sel;
        oOwner   <= sel;
        oData_tx <= iData[sel*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: expected launches queue up as stimulus
// is issued and a negedge monitor pops them whenever oStart fires.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 15;
  localparam int W           = 2 + DATA_W;

  logic                      iClk;
  logic                      iRst;
  logic [NUM_REQ-1:0]        iReq;
  logic [NUM_REQ*DATA_W-1:0] iData;
  logic [NUM_REQ-1:0]        oGnt;
  logic                      oStart;
  logic [DATA_W-1:0]         oData_tx;
  logic                      iBusy_tx;
  logic [1:0]                oOwner;
  logic                      oIdle;
  logic                      oTimeout;
  logic [1:0]                oState;

  logic busy_model, busy_force, busy_auto;
  int   busy_cnt;
  int   busy_len;

  int checks;
  int errors;
  logic [W-1:0]       exp_q[$];
  logic [NUM_REQ-1:0] gnt_seen;

  assign iBusy_tx = busy_model | busy_force;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iData(iData),
    .oGnt(oGnt), .oStart(oStart), .oData_tx(oData_tx), .iBusy_tx(iBusy_tx),
    .oOwner(oOwner), .oIdle(oIdle), .oTimeout(oTimeout), .oState(oState)
  );

  // clock / reset
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // transmitter model: busy for busy_len cycles after each start pulse
  always @(negedge iClk) begin
    if (iRst) begin
      busy_model = 1'b0;
      busy_cnt   = 0;
    end else if (oStart && busy_auto) begin
      busy_model = 1'b1;
      busy_cnt   = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) busy_model = 1'b0;
    end
  end

  // scoreboard monitor
  always @(negedge iClk) begin
    logic [W-1:0]       e;
    logic [NUM_REQ-1:0] exp_gnt;
    if (!iRst) begin
      if (oGnt != '0) begin
        checks++;
        if (!$onehot(oGnt) || iBusy_tx) begin
          errors++;
          $display("FAIL gnt_shape: oGnt=%b busy=%b, required one-hot with busy low", oGnt, iBusy_tx);
        end
        gnt_seen = oGnt;
      end
      if ((oGnt != '0) || oStart || oTimeout) begin
        checks++;
        if (int'(oGnt != '0) + int'(oStart) + int'(oTimeout) > 1) begin
          errors++;
          $display("FAIL exclusive: gnt=%b start=%b timeout=%b, required at most one", oGnt, oStart, oTimeout);
        end
      end
      if (oStart) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL launch: unexpected start owner=%0d data=%h, required no launch", oOwner, oData_tx);
        end else begin
          e       = exp_q.pop_front();
          exp_gnt = 4'b0001 << e[W-1:DATA_W];
          if ({oOwner, oData_tx} !== e || gnt_seen !== exp_gnt) begin
            errors++;
            $display("FAIL launch: owner=%0d data=%h gnt=%b, required owner=%0d data=%h gnt=%b",
                     oOwner, oData_tx, gnt_seen, e[W-1:DATA_W], e[DATA_W-1:0], exp_gnt);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int owner, input logic [DATA_W-1:0] d);
    exp_q.push_back({2'(owner), d});
  endtask

  task automatic wait_gnt(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    while (idx < 0 && cyc < 100) begin
      @(negedge iClk);
      cyc++;
      for (int k = 0; k < NUM_REQ; k++) if (oGnt[k]) idx = k;
    end
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL gnt_wait: no grant within %0d cycles, required a grant", cyc);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    do begin
      @(negedge iClk);
      n++;
    end while (!oIdle && n < 100);
    check("idle_wait", int'(oIdle), 1);
  endtask

  initial begin
    int idx, cyc, n;
    int order[5];
    order      = '{0, 1, 2, 3, 0};
    checks     = 0;
    errors     = 0;
    gnt_seen   = '0;
    busy_force = 1'b0;
    busy_auto  = 1'b1;
    busy_len   = 10;
    busy_model = 1'b0;
    busy_cnt   = 0;
    iData      = {8'h74, 8'h63, 8'h52, 8'h41};
    iReq       = 4'b1111;
    iRst       = 1'b1;

    // reset values, with requests pending to prove grants are held off
    repeat (2) @(negedge iClk);
    check("rst_gnt", int'(oGnt), 0);
    check("rst_start", int'(oStart), 0);
    check("rst_timeout", int'(oTimeout), 0);
    check("rst_data", int'(oData_tx), 0);
    check("rst_owner", int'(oOwner), 0);
    check("rst_idle", int'(oIdle), 1);

    // fairness: all requesting, order 0,1,2,3,0
    for (int i = 0; i < 5; i++) push(order[i], 8'h41 + 8'(order[i] * 17));
    step();
    iRst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(idx, cyc);
      check("rr_order", idx, order[i]);
    end
    step();
    iReq = 4'b0000;
    wait_idle();

    // single request: start one cycle after grant, idle 12 cycles after grant
    step();
    iReq = 4'b0001;
    push(0, 8'h41);
    wait_gnt(idx, cyc);
    check("single_idx", idx, 0);
    step();
    iReq = 4'b0000;
    n = 0;
    do begin
      @(negedge iClk);
      n++;
      if (n == 1) check("single_start_lat", int'(oStart), 1);
    end while (!oIdle && n < 60);
    check("single_idle_lat", n, 12);

    // busy at entry blocks the grant until busy drops
    step();
    busy_force = 1'b1;
    iReq       = 4'b0100;
    push(2, 8'h63);
    repeat (5) begin
      @(negedge iClk);
      check("busy_block", int'(oGnt), 0);
    end
    step();
    busy_force = 1'b0;
    wait_gnt(idx, cyc);
    check("busy_release_idx", idx, 2);
    check("busy_release_lat", cyc, 1);
    step();
    iReq = 4'b0000;
    wait_idle();

    // skip and wrap: last grant 2, requests 0 and 1
    step();
    iReq = 4'b0011;
    push(0, 8'h41);
    push(1, 8'h52);
    wait_gnt(idx, cyc);
    check("wrap_first", idx, 0);
    step();
    iReq = 4'b0010;
    wait_gnt(idx, cyc);
    check("wrap_second", idx, 1);
    step();
    iReq = 4'b0000;
    wait_idle();

    // timeout: no busy after launch, then the next requester in order wins
    step();
    busy_auto = 1'b0;
    iReq      = 4'b0100;
    push(2, 8'h63);
    wait_gnt(idx, cyc);
    check("to_idx", idx, 2);
    step();
    iReq = 4'b1111;
    push(3, 8'h74);
    n = 0;
    do begin
      @(negedge iClk);
      n++;
    end while (!oTimeout && n < 60);
    check("to_latency", n, ACK_TIMEOUT + 2);
    step();
    busy_auto = 1'b1;
    wait_gnt(idx, cyc);
    check("to_next_idx", idx, 3);
    check("to_next_lat", cyc, 1);

    // reset during WAIT_DONE
    repeat (4) @(negedge iClk);
    check("mid_state_busy", int'(oIdle), 0);
    iRst = 1'b1;
    #1;
    check("mid_rst_idle", int'(oIdle), 1);
    check("mid_rst_gnt", int'(oGnt), 0);
    check("mid_rst_start", int'(oStart), 0);
    check("mid_rst_data", int'(oData_tx), 0);
    check("mid_rst_owner", int'(oOwner), 0);
    repeat (2) begin
      @(negedge iClk);
      check("mid_rst_hold_start", int'(oStart), 0);
      check("mid_rst_hold_gnt", int'(oGnt), 0);
    end
    step();
    push(0, 8'h41);
    iRst = 1'b0;
    wait_gnt(idx, cyc);
    check("post_rst_idx", idx, 0);
    check("post_rst_lat", cyc, 1);
    step();
    iReq = 4'b0000;
    wait_idle();

    repeat (2) @(negedge iClk);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
